jump_ctrl: RTL and testbench
============================

JUMP_CTRL -- requirements
Module: jump_ctrl

Interface
- REQ-001 The block SHALL have parameter ADDR_W, default 10, PC/instruction-address width.
- REQ-002 The block SHALL have parameter INS_W, default 16, instruction word width.
- REQ-003 The block SHALL have parameter STACK_DEPTH, default 4, return-stack entries.
- REQ-004 The block SHALL have port clk, input, 1 bit, system clock; all state updates on posedge.
- REQ-005 The block SHALL have port rst, input, 1 bit, reset, asynchronous, active-high.
- REQ-006 The block SHALL have port addr_ins, input, ADDR_W bits, current PC value.
- REQ-007 The block SHALL have port ins, input, INS_W bits, fetched instruction.
- REQ-008 The block SHALL have port ins_valid, input, 1 bit, ins is valid this cycle.
- REQ-009 The block SHALL have port ins_ready, output, 1 bit, block accepts ins this cycle.
- REQ-010 The block SHALL have port zero_flag, input, 1 bit, ALU zero flag for JZ.
- REQ-011 The block SHALL have port pc_load, output, 1 bit, PC load strobe.
- REQ-012 The block SHALL have port jump_ins, output, ADDR_W bits, PC load target.
- REQ-013 The block SHALL have port stack_err, output, 1 bit, sticky stack overflow/underflow flag.

Function
- REQ-014 Opcode = ins[INS_W-1:INS_W-4]: JMP=4'hA, JZ=4'hB, CALL=4'hC, RET=4'hD; the target SHALL be ins[ADDR_W-1:0], and all other opcodes SHALL be non-jump.
- REQ-015 The FSM SHALL have states IDLE, EXEC, LOAD and FLUSH, and SHALL drive ins_ready=1 only in IDLE and FLUSH.
- REQ-016 IDLE: on ins_valid&&ins_ready, the FSM SHALL latch ins into ins_q and addr_ins into pc_q, then go to EXEC; with no ins_valid it SHALL stay in IDLE.
- REQ-017 EXEC: the jump SHALL be taken for JMP, for JZ with zero_flag==1 sampled in EXEC, for CALL with the stack not full, and for RET with the stack not empty; a taken jump SHALL go to LOAD, otherwise the FSM SHALL go to IDLE.
- REQ-018 LOAD: pc_load SHALL be 1 for exactly one cycle and jump_ins SHALL hold the target, which is the ins_q field or, for RET, the popped address; the FSM SHALL then go to FLUSH.
- REQ-019 FLUSH: the next accepted instruction SHALL be discarded, because it is a stale sequential fetch; the FSM SHALL then go to IDLE; it SHALL wait in FLUSH while ins_valid==0.
- REQ-020 jump_ins SHALL hold its last value outside LOAD.
- REQ-021 CALL SHALL push (pc_q+1) mod 2^ADDR_W, so 1023 pushes 0; RET SHALL pop the top entry; the stack SHALL be LIFO.
- REQ-022 A CALL with the stack full SHALL be not taken, leave the stack unchanged and set stack_err.
- REQ-023 A RET with the stack empty SHALL be not taken and set stack_err.
- REQ-024 stack_err SHALL stay at 1 until rst.
- REQ-025 Latency SHALL be 2 cycles from acceptance to pc_load and 1 cycle from acceptance for a not-taken instruction to return to IDLE.

Reset
- REQ-026 While rst=1, the block SHALL force immediately: state=IDLE, pc_load=0, jump_ins=0, stack_err=0, stack pointer=0 (empty), ins_ready=0.
- REQ-027 rst SHALL dominate every other event, including rst asserted during LOAD, which SHALL drop pc_load at once.
- REQ-028 After rst deassertion, ins_ready SHALL be 1 at the first posedge.

Configuration
- REQ-029 With macro JUMP_CTRL_RET_STACK_EN defined, CALL/RET and the return stack SHALL behave as in REQ-021 to REQ-024.
- REQ-030 Without JUMP_CTRL_RET_STACK_EN, CALL SHALL behave exactly as JMP, RET SHALL be non-jump, no stack storage SHALL exist, and stack_err SHALL be tied to 0.

Structure
- REQ-031 Package jump_ctrl_pkg SHALL hold the opcode constants (OP_JMP, OP_JZ, OP_CALL, OP_RET), the FSM state typedef, and the default widths.
- REQ-032 The return stack SHALL be sub-module ret_stack, with push/pop/full/empty/top ports, instantiated only under JUMP_CTRL_RET_STACK_EN.

Verification
- REQ-033 ins=16'hA123, valid at pc 5 -> pc_load pulse 2 cycles later with jump_ins=10'h123; the next instruction is dropped; ins_ready returns to 1.
- REQ-034 JZ 16'hB040 with zero_flag=0 -> no pc_load, FSM back in IDLE after 1 cycle; the same instruction with zero_flag=1 -> jump_ins=10'h040.
- REQ-035 CALL 16'hC200 at pc 10'h3FF, then RET -> the first jump_ins=10'h200, and the RET jump_ins=10'h000 (wrap).
- REQ-036 Five CALLs with STACK_DEPTH=4 -> the fifth is not taken and stack_err=1; then RET on an empty stack leaves stack_err=1 and causes no pc_load.
- REQ-037 rst asserted during LOAD -> pc_load=0 immediately and all outputs at their REQ-026 values; build without JUMP_CTRL_RET_STACK_EN, CALL 16'hC055 -> jump_ins=10'h055 and stack_err=0.

Source files
------------

// File: rtl/jump_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jump_ctrl_pkg
// Purpose  : Shared definitions for the jump controller. It holds the default
//            widths, the jump opcode encodings and the controller state type.
// Revision : 1.0 - initial release
// ============================================================================
package jump_ctrl_pkg;

    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_INS_W       = 16;
    localparam int DEF_STACK_DEPTH = 4;

    // Opcodes are taken from the top nibble of the instruction word
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_CALL = 4'hC;
    localparam logic [3:0] OP_RET  = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

endpackage : jump_ctrl_pkg
`default_nettype wire

// File: rtl/jump_ctrl_ret_stack.sv
`default_nettype none
// ============================================================================
// Module   : ret_stack
// Purpose  : LIFO return-address stack for CALL/RET.
//            push : write push_data on top (ignored when full)
//            pop  : drop the top entry (ignored when empty)
//            full / empty : occupancy flags
//            top  : current top entry (undefined while empty)
//            rst  : asynchronous, active-high; empties the stack
// Revision : 1.0 - initial release
// ============================================================================
module ret_stack
    import jump_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] top
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_sp;          // number of valid entries
    logic [IDX_W-1:0]  w_top_idx;
    logic [IDX_W-1:0]  w_wr_idx;

    assign full      = (r_sp == PTR_W'(DEPTH));
    assign empty     = (r_sp == '0);
    assign w_top_idx = IDX_W'(r_sp - PTR_W'(1));
    assign w_wr_idx  = IDX_W'(r_sp);
    assign top       = r_mem[w_top_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp <= '0;
        end else if (push && !full) begin
            r_sp <= r_sp + PTR_W'(1);
        end else if (pop && !empty) begin
            r_sp <= r_sp - PTR_W'(1);
        end
    end

    // Storage needs no reset: only entries below r_sp are ever read
    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

endmodule : ret_stack
`default_nettype wire

// File: rtl/jump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jump_ctrl
// Purpose  : Decodes fetched jump instructions (JMP/JZ/CALL/RET) and issues
//            a one-cycle PC load strobe with the target. The stale sequential
//            fetch after every taken jump is then discarded.
// Ports    : clk, rst (async, active-high)
//            addr_ins/ins/ins_valid/ins_ready : instruction handshake
//            zero_flag : ALU zero flag, sampled in EXEC for JZ
//            pc_load/jump_ins : PC load strobe and target
//            stack_err : sticky return-stack overflow/underflow flag
// Config   : JUMP_CTRL_RET_STACK_EN enables the CALL/RET return stack.
//            Without it CALL acts as JMP, RET is non-jump, stack_err = 0.
// Revision : 1.0 - initial release
// ============================================================================
module jump_ctrl
    import jump_ctrl_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int INS_W       = DEF_INS_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_ins,
    input  logic [INS_W-1:0]  ins,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic              zero_flag,
    output logic              pc_load,
    output logic [ADDR_W-1:0] jump_ins,
    output logic              stack_err
);

    state_t            r_state;
    logic [INS_W-1:0]  r_ins_q;
    logic [ADDR_W-1:0] r_pc_q;

    logic [3:0]        w_opcode;
    logic [ADDR_W-1:0] w_field;
    logic              w_accept;
    logic              w_taken;
    logic [ADDR_W-1:0] w_target;
    logic              w_unused;

    assign w_opcode = r_ins_q[INS_W-1 -: 4];
    assign w_field  = r_ins_q[ADDR_W-1:0];
    assign w_accept = ins_valid & ins_ready;

    // Some latched bits only matter in the stack-enabled build
    assign w_unused = ^{r_ins_q, r_pc_q, 32'(STACK_DEPTH)};

`ifdef JUMP_CTRL_RET_STACK_EN
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_err;
    logic [ADDR_W-1:0] w_top;
    logic [ADDR_W-1:0] w_ret_addr;
    logic              r_stack_err;

    // Return address wraps naturally at 2^ADDR_W
    assign w_ret_addr = r_pc_q + ADDR_W'(1);
    assign stack_err  = r_stack_err;

    always_comb begin
        w_taken  = 1'b0;
        w_target = w_field;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        w_err    = 1'b0;
        if (r_state == ST_EXEC) begin
            unique case (w_opcode)
                OP_JMP:  w_taken = 1'b1;
                OP_JZ:   w_taken = zero_flag;
                OP_CALL: begin
                    if (!w_full) begin
                        w_taken = 1'b1;
                        w_push  = 1'b1;
                    end else begin
                        w_err   = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!w_empty) begin
                        w_taken  = 1'b1;
                        w_pop    = 1'b1;
                        w_target = w_top;
                    end else begin
                        w_err    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    ret_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_ret_addr),
        .full      (w_full),
        .empty     (w_empty),
        .top       (w_top)
    );
`else
    assign stack_err = 1'b0;

    always_comb begin
        w_taken  = 1'b0;
        w_target = w_field;
        if (r_state == ST_EXEC) begin
            unique case (w_opcode)
                OP_JMP:  w_taken = 1'b1;
                OP_JZ:   w_taken = zero_flag;
                OP_CALL: w_taken = 1'b1;
                default: ;
            endcase
        end
    end
`endif

    // Outputs are registered, so ins_ready reflects the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ins_q     <= '0;
            r_pc_q      <= '0;
            ins_ready   <= 1'b0;
            pc_load     <= 1'b0;
            jump_ins    <= '0;
`ifdef JUMP_CTRL_RET_STACK_EN
            r_stack_err <= 1'b0;
`endif
        end else begin
            pc_load <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    ins_ready <= 1'b1;
                    if (w_accept) begin
                        r_ins_q   <= ins;
                        r_pc_q    <= addr_ins;
                        r_state   <= ST_EXEC;
                        ins_ready <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    if (w_taken) begin
                        r_state  <= ST_LOAD;
                        pc_load  <= 1'b1;
                        jump_ins <= w_target;
                    end else begin
                        r_state   <= ST_IDLE;
                        ins_ready <= 1'b1;
                    end
`ifdef JUMP_CTRL_RET_STACK_EN
                    if (w_err) begin
                        r_stack_err <= 1'b1;
                    end
`endif
                end
                ST_LOAD: begin
                    r_state   <= ST_FLUSH;
                    ins_ready <= 1'b1;
                end
                ST_FLUSH: begin
                    // The accepted word is the stale fall-through fetch
                    if (w_accept) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : jump_ctrl
`default_nettype wire

// File: tb/tb_jump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jump_ctrl
// Purpose  : Self-checking bench for jump_ctrl. Expected PC loads are queued
//            by a behavioural model on each accepted instruction and popped
//            by a monitor whenever pc_load is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jump_ctrl;

    localparam int AW = 10;
    localparam int IW = 16;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr_ins;
    logic [IW-1:0] ins;
    logic          ins_valid;
    logic          ins_ready;
    logic          zero_flag;
    logic          pc_load;
    logic [AW-1:0] jump_ins;
    logic          stack_err;

    jump_ctrl #(
        .ADDR_W      (AW),
        .INS_W       (IW),
        .STACK_DEPTH (SD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr_ins  (addr_ins),
        .ins       (ins),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .zero_flag (zero_flag),
        .pc_load   (pc_load),
        .jump_ins  (jump_ins),
        .stack_err (stack_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] tgt;
        int            cyc;
    } exp_t;

    exp_t          sbq[$];
    logic [AW-1:0] exp_ji = '0;
    int            mdl_stk[$];
    bit            mdl_err = 1'b0;
    bit            mdl_flush = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference model: acts on each accepted instruction, in program order
    task automatic model(input logic [IW-1:0] i, input logic [AW-1:0] pc,
                         input bit z, input int h, output bit taken);
        logic [3:0] op;
        int         tgt;
        exp_t       e;
        op    = i[IW-1:IW-4];
        tgt   = int'(i[AW-1:0]);
        taken = 1'b0;
        if (mdl_flush) begin
            mdl_flush = 1'b0;
            return;
        end
        case (op)
            4'hA: taken = 1'b1;
            4'hB: taken = z;
`ifdef JUMP_CTRL_RET_STACK_EN
            4'hC: begin
                if (mdl_stk.size() < SD) begin
                    mdl_stk.push_back((int'(pc) + 1) % (1 << AW));
                    taken = 1'b1;
                end else begin
                    mdl_err = 1'b1;
                end
            end
            4'hD: begin
                if (mdl_stk.size() > 0) begin
                    tgt   = mdl_stk.pop_back();
                    taken = 1'b1;
                end else begin
                    mdl_err = 1'b1;
                end
            end
`else
            4'hC: taken = 1'b1;
`endif
            default: ;
        endcase
        if (taken) begin
            e.tgt = AW'(tgt);
            e.cyc = h + 2;
            sbq.push_back(e);
            mdl_flush = 1'b1;
        end
    endtask

    // Monitor: every pc_load must match the oldest queued expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_pc_load: got none expected target %0h at cycle %0d", e.tgt, e.cyc);
            end
            if (pc_load) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pc_load: got target %0h expected no load at cycle %0d", jump_ins, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("pc_load_cycle", cyc, e.cyc);
                    exp_ji = e.tgt;
                end
            end
            chk("jump_ins", 32'(jump_ins), 32'(exp_ji));
        end
    end

    task automatic send(input logic [IW-1:0] i, input logic [AW-1:0] pc,
                        input bit z, input int gap);
        int n;
        int h;
        bit taken;
        n         = 0;
        ins       = i;
        addr_ins  = pc;
        zero_flag = z;
        ins_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (ins_ready) break;
            n++;
            if (n > 20) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout: got ins_ready 0 expected 1 within 20 cycles");
                ins_valid = 1'b0;
                return;
            end
        end
        h = cyc;
        @(posedge clk);
        #1;
        ins_valid = 1'b0;
        model(i, pc, z, h, taken);
        @(posedge clk);
        #1;
        chk("ready_after_exec", 32'(ins_ready), 32'(!taken));
        chk("stack_err", 32'(stack_err), 32'(mdl_err));
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        mdl_stk.delete();
        sbq.delete();
        mdl_err   = 1'b0;
        mdl_flush = 1'b0;
        exp_ji    = '0;
    endtask

    initial begin
        logic [3:0]    op;
        logic [IW-1:0] rnd;
        rst       = 1'b1;
        ins_valid = 1'b0;
        ins       = '0;
        addr_ins  = '0;
        zero_flag = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_pc_load",   32'(pc_load),   32'd0);
        chk("rst_jump_ins",  32'(jump_ins),  32'd0);
        chk("rst_stack_err", 32'(stack_err), 32'd0);
        chk("rst_ins_ready", 32'(ins_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_first_edge", 32'(ins_ready), 32'd1);

        // JMP, then a stale fetch that must be dropped
        send(16'hA123, 10'd5, 1'b0, 0);
        send(16'hA3FF, 10'd6, 1'b0, 0);
        send(16'h0000, 10'd7, 1'b0, 1);

        // JZ not taken, then taken
        send(16'hB040, 10'd8, 1'b0, 1);
        send(16'hB040, 10'd9, 1'b1, 0);
        send(16'h1000, 10'd10, 1'b0, 0);

        // CALL at the top of the address space, then RET wraps to 0
        send(16'hC200, 10'h3FF, 1'b0, 0);
        send(16'h1000, 10'h000, 1'b0, 0);
        send(16'hD000, 10'h201, 1'b0, 0);
        send(16'h1000, 10'h000, 1'b0, 1);

        // Overflow the stack, then drain it and underflow
        for (int k = 0; k < 5; k++) begin
            send(IW'(16'hC000 + 16'h011 * k), AW'(10'h100 + 3 * k), 1'b0, 0);
            send(16'h2000, 10'h0, 1'b0, 0);
        end
        for (int k = 0; k < 5; k++) begin
            send(16'hD000, AW'(10'h50 + k), 1'b0, 0);
            send(16'h2000, 10'h0, 1'b0, 0);
        end

        // Reset in the middle of LOAD
        send(16'hA2AA, 10'h20, 1'b0, 0);
        @(negedge clk);
        chk("load_pc_load", 32'(pc_load), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_load_pc_load",   32'(pc_load),   32'd0);
        chk("rst_load_jump_ins",  32'(jump_ins),  32'd0);
        chk("rst_load_stack_err", 32'(stack_err), 32'd0);
        chk("rst_load_ins_ready", 32'(ins_ready), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(ins_ready), 32'd1);

        // CALL right after reset
        send(16'hC055, 10'h30, 1'b0, 0);
        send(16'h3000, 10'h31, 1'b0, 1);

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    op = 4'hA;
                2, 3:    op = 4'hB;
                4, 5:    op = 4'hC;
                6, 7:    op = 4'hD;
                default: op = 4'($urandom_range(0, 9));
            endcase
            rnd = IW'($urandom);
            send({op, rnd[IW-5:0]}, AW'($urandom), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)));
        end

        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_jump_ctrl
`default_nettype wire
